// File: rtl/mcd_ssd_pkg.sv
// Shared definitions for the memcached-to-SSD request engine: command word layout,
// transfer limits and FSM state encoding.
package mcd_ssd_pkg;

    localparam int unsigned CMD_ADDR_LSB = 0;
    localparam int unsigned CMD_ADDR_W   = 32;
    localparam int unsigned CMD_LEN_LSB  = 32;
    localparam int unsigned CMD_LEN_W    = 13;
    localparam int unsigned CMD_W        = CMD_LEN_LSB + CMD_LEN_W;

    localparam int unsigned MAX_LEN      = 4096;
    localparam int unsigned BEAT_BYTES   = 8;
    localparam int unsigned BEAT_CNT_W   = 10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_RD_CMD   = 3'd1;
    localparam state_t ST_RD_DATA  = 3'd2;
    localparam state_t ST_WR_CMD   = 3'd3;
    localparam state_t ST_WR_DATA  = 3'd4;
    localparam state_t ST_WR_DRAIN = 3'd5;

    function automatic logic len_legal(input logic [CMD_LEN_W-1:0] len);
        return (len != '0) && (len <= CMD_LEN_W'(MAX_LEN));
    endfunction

    // Round the byte count up to whole 8-byte beats; legal lengths give 1..512.
    function automatic logic [BEAT_CNT_W-1:0] beat_count(input logic [CMD_LEN_W-1:0] len);
        logic [CMD_LEN_W:0] sum;
        sum = {1'b0, len} + (CMD_LEN_W + 1)'(BEAT_BYTES - 1);
        return BEAT_CNT_W'(sum >> $clog2(BEAT_BYTES));
    endfunction

endpackage

// File: rtl/mcd_ssd_beat_cnt.sv
// Remaining-beat counter shared by the read and write data phases.
module mcd_ssd_beat_cnt
    import mcd_ssd_pkg::*;
(
    input  logic                  clk156,
    input  logic                  reset156,
    input  logic                  clr,
    input  logic                  load,
    input  logic [BEAT_CNT_W-1:0] load_val,
    input  logic                  dec,
    output logic                  zero,
    output logic                  last
);

    logic [BEAT_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk156) begin
        if (reset156 || clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_comb begin
        zero = (cnt_q == '0);
        last = (cnt_q == BEAT_CNT_W'(1));
    end

endmodule

// File: rtl/mcd_ssd_req.sv
// Single-outstanding SSD request engine between memcached and a memory node.
// Optional watchdog on the data/drain phases is built when MCD_SSD_REQ_TIMEOUT_EN is defined.
module mcd_ssd_req
    import mcd_ssd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1 << 20
) (
    input  logic              clk156,
    input  logic              reset156,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [31:0]       req_addr,
    input  logic [12:0]       req_len,

    input  logic [63:0]       wr_in_data,
    input  logic              wr_in_valid,
    output logic              wr_in_ready,

    output logic [63:0]       rd_out_data,
    output logic              rd_out_valid,
    input  logic              rd_out_ready,
    output logic              rd_out_last,

    output logic [CMD_W-1:0]  cmd_dramRdData_data,
    output logic              cmd_dramRdData_valid,
    input  logic              cmd_dramRdData_ready,

    output logic [CMD_W-1:0]  cmd_dramWrData_data,
    output logic              cmd_dramWrData_valid,
    input  logic              cmd_dramWrData_ready,

    output logic [63:0]       dramWrData_data,
    output logic              dramWrData_valid,
    input  logic              dramWrData_ready,

    input  logic [63:0]       dramRdData_data,
    input  logic              dramRdData_valid,
    output logic              dramRdData_ready,

    input  logic              link_initialized_clk156,
    input  logic              ncq_idle_clk156,

    output logic              done,
    output logic              err,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [CMD_W-1:0]  cmd_q;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              req_hs;
    logic              cmd_rd_hs, cmd_wr_hs;
    logic              rd_data_en, wr_data_en;
    logic              rd_hs, wr_hs;
    logic              cnt_zero, cnt_last;
    logic              abort;
    logic              wd_expire;

    // Data paths open only in their own phase, with the link up and beats still owed.
    always_comb begin
        req_ready  = (state_q == ST_IDLE) && link_initialized_clk156 && !reset156;
        req_hs     = req_valid && req_ready;

        cmd_dramRdData_valid = (state_q == ST_RD_CMD) && link_initialized_clk156;
        cmd_dramWrData_valid = (state_q == ST_WR_CMD) && link_initialized_clk156;
        cmd_dramRdData_data  = cmd_q;
        cmd_dramWrData_data  = cmd_q;
        cmd_rd_hs = cmd_dramRdData_valid && cmd_dramRdData_ready;
        cmd_wr_hs = cmd_dramWrData_valid && cmd_dramWrData_ready;

        rd_data_en = (state_q == ST_RD_DATA) && link_initialized_clk156 && !cnt_zero;
        wr_data_en = (state_q == ST_WR_DATA) && link_initialized_clk156 && !cnt_zero;

        rd_out_data      = dramRdData_data;
        rd_out_valid     = rd_data_en && dramRdData_valid;
        dramRdData_ready = rd_data_en && rd_out_ready;
        rd_out_last      = rd_data_en && cnt_last;
        rd_hs            = rd_out_valid && rd_out_ready;

        dramWrData_data  = wr_in_data;
        dramWrData_valid = wr_data_en && wr_in_valid;
        wr_in_ready      = wr_data_en && dramWrData_ready;
        wr_hs            = dramWrData_valid && dramWrData_ready;

        done = done_q;
        err  = err_q;
        busy = (state_q != ST_IDLE);
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_hs) begin
                    if (len_legal(req_len)) begin
                        state_d = req_wr ? ST_WR_CMD : ST_RD_CMD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RD_CMD: begin
                if (cmd_rd_hs) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (rd_hs && cnt_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_WR_CMD: begin
                if (cmd_wr_hs) state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                if (wr_hs && cnt_last) state_d = ST_WR_DRAIN;
            end
            ST_WR_DRAIN: begin
                if (ncq_idle_clk156) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Link loss or watchdog expiry abandons whatever transfer is in flight.
        if ((state_q != ST_IDLE) && (!link_initialized_clk156 || wd_expire)) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b1;
            abort   = 1'b1;
        end
    end

    always_ff @(posedge clk156) begin
        if (reset156) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (req_hs) begin
                cmd_q[CMD_ADDR_LSB +: CMD_ADDR_W] <= req_addr;
                cmd_q[CMD_LEN_LSB +: CMD_LEN_W]   <= req_len;
            end
        end
    end

    mcd_ssd_beat_cnt u_beat_cnt (
        .clk156   (clk156),
        .reset156 (reset156),
        .clr      (abort),
        .load     (cmd_rd_hs || cmd_wr_hs),
        .load_val (beat_count(cmd_q[CMD_LEN_LSB +: CMD_LEN_W])),
        .dec      (rd_hs || wr_hs),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

`ifdef MCD_SSD_REQ_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WdW-1:0] wd_q;
    logic           wd_active;

    always_comb begin
        wd_active = (state_q == ST_RD_DATA) || (state_q == ST_WR_DATA) ||
                    (state_q == ST_WR_DRAIN);
        // wd_q counts completed idle cycles, so this fires on the TIMEOUT_CYCLES-th one.
        wd_expire = wd_active && (wd_q == WdW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk156) begin
        if (reset156 || !wd_active || (state_d != state_q) || rd_hs || wr_hs) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;

    // TIMEOUT_CYCLES only shapes the watchdog; keep it referenced when that is left out.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

endmodule

// File: tb/tb_mcd_ssd_req.sv
// Directed bench for mcd_ssd_req; the watchdog step runs when MCD_SSD_REQ_TIMEOUT_EN is set.
module tb_mcd_ssd_req;

    logic        clk156 = 1'b0;
    logic        reset156;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr;
    logic [12:0] req_len;
    logic [63:0] wr_in_data;
    logic        wr_in_valid, wr_in_ready;
    logic [63:0] rd_out_data;
    logic        rd_out_valid, rd_out_ready, rd_out_last;
    logic [44:0] cmd_dramRdData_data;
    logic        cmd_dramRdData_valid, cmd_dramRdData_ready;
    logic [44:0] cmd_dramWrData_data;
    logic        cmd_dramWrData_valid, cmd_dramWrData_ready;
    logic [63:0] dramWrData_data;
    logic        dramWrData_valid, dramWrData_ready;
    logic [63:0] dramRdData_data;
    logic        dramRdData_valid, dramRdData_ready;
    logic        link_initialized_clk156, ncq_idle_clk156;
    logic        done, err, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk156 = ~clk156;

    mcd_ssd_req #(.TIMEOUT_CYCLES(16)) dut (
        .clk156                  (clk156),
        .reset156                (reset156),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_wr                  (req_wr),
        .req_addr                (req_addr),
        .req_len                 (req_len),
        .wr_in_data              (wr_in_data),
        .wr_in_valid             (wr_in_valid),
        .wr_in_ready             (wr_in_ready),
        .rd_out_data             (rd_out_data),
        .rd_out_valid            (rd_out_valid),
        .rd_out_ready            (rd_out_ready),
        .rd_out_last             (rd_out_last),
        .cmd_dramRdData_data     (cmd_dramRdData_data),
        .cmd_dramRdData_valid    (cmd_dramRdData_valid),
        .cmd_dramRdData_ready    (cmd_dramRdData_ready),
        .cmd_dramWrData_data     (cmd_dramWrData_data),
        .cmd_dramWrData_valid    (cmd_dramWrData_valid),
        .cmd_dramWrData_ready    (cmd_dramWrData_ready),
        .dramWrData_data         (dramWrData_data),
        .dramWrData_valid        (dramWrData_valid),
        .dramWrData_ready        (dramWrData_ready),
        .dramRdData_data         (dramRdData_data),
        .dramRdData_valid        (dramRdData_valid),
        .dramRdData_ready        (dramRdData_ready),
        .link_initialized_clk156 (link_initialized_clk156),
        .ncq_idle_clk156         (ncq_idle_clk156),
        .done                    (done),
        .err                     (err),
        .busy                    (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk156);
        @(negedge clk156);
    endtask

    // Called at a negedge; returns at the negedge after acceptance with req_valid dropped.
    task automatic issue_req(input logic wr, input logic [31:0] addr, input logic [12:0] len);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_len   = len;
        #1;
        chk("req_ready_idle", req_ready, 1);
        next_cycle();
        req_valid = 1'b0;
    endtask

    // Holds the command one cycle unacknowledged, then completes the handshake.
    task automatic cmd_hs(input logic wr, input logic [44:0] exp);
        #1;
        chk("cmd_rd_valid", cmd_dramRdData_valid, 64'(!wr));
        chk("cmd_wr_valid", cmd_dramWrData_valid, 64'(wr));
        chk("cmd_data", wr ? cmd_dramWrData_data : cmd_dramRdData_data, exp);
        chk("busy_cmd", busy, 1);
        next_cycle();
        #1;
        chk("cmd_held", wr ? cmd_dramWrData_valid : cmd_dramRdData_valid, 1);
        if (wr) cmd_dramWrData_ready = 1'b1;
        else    cmd_dramRdData_ready = 1'b1;
        next_cycle();
        cmd_dramWrData_ready = 1'b0;
        cmd_dramRdData_ready = 1'b0;
        #1;
        chk("cmd_rd_dropped", cmd_dramRdData_valid, 0);
        chk("cmd_wr_dropped", cmd_dramWrData_valid, 0);
    endtask

    task automatic rd_beat(input int i, input logic last_exp);
        dramRdData_valid = 1'b1;
        dramRdData_data  = 64'hA000 + 64'(i);
        rd_out_ready     = 1'b1;
        #1;
        chk("rd_out_valid", rd_out_valid, 1);
        chk("rd_out_data", rd_out_data, 64'hA000 + 64'(i));
        chk("rd_out_last", rd_out_last, 64'(last_exp));
        chk("rd_ready_thru", dramRdData_ready, 1);
        chk("done_mid_rd", done, 0);
        next_cycle();
        dramRdData_valid = 1'b0;
        rd_out_ready     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset156 = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
        wr_in_data = '0; wr_in_valid = 1'b0;
        rd_out_ready = 1'b0;
        cmd_dramRdData_ready = 1'b0; cmd_dramWrData_ready = 1'b0;
        dramWrData_ready = 1'b0;
        dramRdData_data = '0; dramRdData_valid = 1'b0;
        link_initialized_clk156 = 1'b1;
        ncq_idle_clk156 = 1'b1;

        // Reset state
        @(negedge clk156);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cmd_rd_valid", cmd_dramRdData_valid, 0);
        chk("rst_cmd_wr_valid", cmd_dramWrData_valid, 0);
        chk("rst_cmd_data", cmd_dramRdData_data, 0);
        reset156 = 1'b0;
        #1;
        chk("post_rst_req_ready", req_ready, 1);

        // Read 64 bytes at 0x200: 8 beats, one consumer stall before beat 2
        issue_req(1'b0, 32'h200, 13'd64);
        cmd_hs(1'b0, {13'd64, 32'h200});
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                dramRdData_valid = 1'b1;
                dramRdData_data  = 64'hA002;
                rd_out_ready     = 1'b0;
                #1;
                chk("rd_stall_ready", dramRdData_ready, 0);
                next_cycle();
            end
            rd_beat(i, i == 7);
        end
        #1;
        chk("rd_done", done, 1);
        chk("rd_busy_after", busy, 0);
        chk("rd_err_none", err, 0);
        next_cycle();
        #1;
        chk("rd_done_pulse", done, 0);

        // Write 13 bytes: 2 beats, node back-pressures 5 cycles, drain waits for ncq_idle
        ncq_idle_clk156 = 1'b0;
        issue_req(1'b1, 32'h400, 13'd13);
        cmd_hs(1'b1, {13'd13, 32'h400});
        wr_in_valid = 1'b1;
        wr_in_data  = 64'hD0;
        repeat (5) begin
            #1;
            chk("wr_bp_valid", dramWrData_valid, 1);
            chk("wr_bp_data", dramWrData_data, 64'hD0);
            chk("wr_bp_ready", wr_in_ready, 0);
            next_cycle();
        end
        dramWrData_ready = 1'b1;
        #1;
        chk("wr_beat0_ready", wr_in_ready, 1);
        chk("wr_beat0_data", dramWrData_data, 64'hD0);
        next_cycle();
        wr_in_data = 64'hD1;
        #1;
        chk("wr_beat1_valid", dramWrData_valid, 1);
        chk("wr_beat1_data", dramWrData_data, 64'hD1);
        next_cycle();
        wr_in_data = 64'hD2;
        repeat (3) begin
            #1;
            chk("drain_no_fwd", dramWrData_valid, 0);
            chk("drain_no_ready", wr_in_ready, 0);
            chk("drain_busy", busy, 1);
            chk("drain_no_done", done, 0);
            next_cycle();
        end
        ncq_idle_clk156 = 1'b1;
        next_cycle();
        wr_in_valid = 1'b0;
        dramWrData_ready = 1'b0;
        #1;
        chk("wr_done", done, 1);
        chk("wr_busy_after", busy, 0);
        next_cycle();
        #1;
        chk("wr_done_pulse", done, 0);

        // Illegal lengths 0 and 4097
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h200; req_len = 13'd0;
        #1;
        chk("ill0_req_ready", req_ready, 1);
        next_cycle();
        req_len = 13'd4097;
        #1;
        chk("ill0_err", err, 1);
        chk("ill0_busy", busy, 0);
        chk("ill0_cmd_rd", cmd_dramRdData_valid, 0);
        next_cycle();
        req_valid = 1'b0;
        #1;
        chk("ill4097_err", err, 1);
        chk("ill4097_busy", busy, 0);
        chk("ill4097_cmd_rd", cmd_dramRdData_valid, 0);
        chk("ill4097_cmd_wr", cmd_dramWrData_valid, 0);
        next_cycle();
        #1;
        chk("ill_err_pulse", err, 0);
        chk("ill_cmd_rd_after", cmd_dramRdData_valid, 0);

        // Link drop during read after 3 of 8 beats
        issue_req(1'b0, 32'h600, 13'd64);
        cmd_hs(1'b0, {13'd64, 32'h600});
        for (int i = 0; i < 3; i++) rd_beat(i, 1'b0);
        link_initialized_clk156 = 1'b0;
        dramRdData_valid = 1'b1;
        rd_out_ready = 1'b1;
        #1;
        chk("link_rd_valid_blocked", rd_out_valid, 0);
        chk("link_rd_ready_blocked", dramRdData_ready, 0);
        next_cycle();
        dramRdData_valid = 1'b0;
        rd_out_ready = 1'b0;
        #1;
        chk("link_err", err, 1);
        chk("link_busy", busy, 0);
        chk("link_done", done, 0);
        chk("link_req_ready", req_ready, 0);
        next_cycle();
        #1;
        chk("link_err_pulse", err, 0);
        chk("link_req_ready_held", req_ready, 0);
        link_initialized_clk156 = 1'b1;
        #1;
        chk("link_back_req_ready", req_ready, 1);

        // Reset mid-write, then a one-beat read completes
        issue_req(1'b1, 32'h800, 13'd64);
        cmd_hs(1'b1, {13'd64, 32'h800});
        wr_in_valid = 1'b1;
        dramWrData_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_in_data = 64'hE0 + 64'(i);
            #1;
            chk("rstw_beat_valid", dramWrData_valid, 1);
            next_cycle();
        end
        reset156 = 1'b1;
        next_cycle();
        #1;
        chk("rstw_wr_valid", dramWrData_valid, 0);
        chk("rstw_wr_ready", wr_in_ready, 0);
        chk("rstw_rd_valid", rd_out_valid, 0);
        chk("rstw_req_ready", req_ready, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_done", done, 0);
        chk("rstw_err", err, 0);
        reset156 = 1'b0;
        wr_in_valid = 1'b0;
        dramWrData_ready = 1'b0;
        next_cycle();
        #1;
        chk("rstw_after_err", err, 0);
        chk("rstw_after_done", done, 0);
        issue_req(1'b0, 32'hA00, 13'd8);
        cmd_hs(1'b0, {13'd8, 32'hA00});
        rd_beat(0, 1'b1);
        #1;
        chk("rstw_rd_done", done, 1);
        chk("rstw_rd_err", err, 0);
        next_cycle();

`ifdef MCD_SSD_REQ_TIMEOUT_EN
        // Read with no data from the node: 16 RD_DATA cycles, then err and IDLE
        begin
            int  n;
            logic seen;
            n = 1;
            seen = 1'b0;
            issue_req(1'b0, 32'hC00, 13'd64);
            cmd_hs(1'b0, {13'd64, 32'hC00});
            while ((n <= 40) && !seen) begin
                #1;
                if (err) seen = 1'b1;
                else begin
                    next_cycle();
                    n++;
                end
            end
            chk("wd_err_seen", 64'(seen), 1);
            chk("wd_err_cycle", 64'(n), 17);
            chk("wd_busy", busy, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcd_ssd_req.md
MCD_SSD_REQ -- requirements
Module: mcd_ssd_req

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 2^20, clk156 cycles allowed per data/drain phase before abort.
REQ-002 clk156  in  1  sole clock; all logic on its rising edge.
REQ-003 reset156  in  1  synchronous, active-high reset.
REQ-004 req_valid/req_ready  in/out  1/1  upstream request handshake.
REQ-005 req_wr  in  1  1=write to SSD, 0=read.
REQ-006 req_addr  in  32  byte address, 512-byte aligned.
REQ-007 req_len  in  13  byte count, legal 1..4096.
REQ-008 wr_in_data/valid/ready  in/in/out  64/1/1  write payload from memcached.
REQ-009 rd_out_data/valid/ready/last  out/out/in/out  64/1/1/1  read payload to memcached.
REQ-010 cmd_dramRdData_data/valid/ready  out/out/in  45/1/1  read command to memory node.
REQ-011 cmd_dramWrData_data/valid/ready  out/out/in  45/1/1  write command to memory node.
REQ-012 dramWrData_data/valid/ready  out/out/in  64/1/1  write payload to memory node.
REQ-013 dramRdData_data/valid/ready  in/in/out  64/1/1  read payload from memory node.
REQ-014 link_initialized_clk156, ncq_idle_clk156  in  1 each  node status, already synchronised.
REQ-015 done / err / busy  out  1/1/1  done and err are one-cycle pulses; busy is a level.

Function
REQ-016 Command word: [31:0]=req_addr, [44:32]=req_len; registered at acceptance, stable while valid is high.
REQ-017 Beat count = (req_len+7)>>3, 10 bits, range 1..512; last beat carries no byte mask.
REQ-018 FSM states: IDLE, RD_CMD, RD_DATA, WR_CMD, WR_DATA, WR_DRAIN.
REQ-019 req_ready=1 only in IDLE with link_initialized_clk156=1; exactly one request is outstanding.
REQ-020 IDLE: accepted legal read -> RD_CMD; accepted legal write -> WR_CMD.
REQ-021 Illegal req_len (0 or >4096) is accepted; err pulses the next cycle; no command is issued; FSM stays in IDLE.
REQ-022 RD_CMD: cmd_dramRdData_valid=1 until ready; on handshake -> RD_DATA.
REQ-023 RD_DATA: rd_out_* is a combinational pass-through of dramRdData_*, including ready.
REQ-024 RD_DATA: rd_out_last=1 on the final counted beat; at that handshake done pulses the next cycle and FSM -> IDLE.
REQ-025 WR_CMD: cmd_dramWrData_valid=1 until ready; on handshake -> WR_DATA.
REQ-026 WR_DATA: dramWrData_* is a combinational pass-through of wr_in_*; after the final counted beat -> WR_DRAIN.
REQ-027 WR_DRAIN: wait for ncq_idle_clk156=1; done pulses the next cycle; FSM -> IDLE.
REQ-028 Outside its phase each forwarding path holds valid=0 and ready=0; no beat is forwarded or dropped.
REQ-029 link_initialized_clk156 falling in any non-IDLE state: FSM -> IDLE next cycle; err pulses; beat counter clears.
REQ-030 busy = (state != IDLE).
REQ-031 Beat counter loads at the command handshake, decrements per data handshake, and never wraps below 0.

Reset
REQ-032 reset156=1 forces IDLE, clears counters and command register, and drives all valid/ready outputs plus done, err and busy to 0 on the next edge.
REQ-033 Reset asserted mid-transfer abandons the transfer with no done and no err; the first cycle after release is IDLE.

Configuration
REQ-034 Macro MCD_SSD_REQ_TIMEOUT_EN defined: a watchdog counts cycles in RD_DATA, WR_DATA and WR_DRAIN, clearing on every data handshake and on every state change.
REQ-035 Watchdog reaching TIMEOUT_CYCLES: err pulses; FSM -> IDLE.
REQ-036 Macro undefined: no watchdog logic is present; only REQ-021 and REQ-029 can raise err.

Structure
REQ-037 Package mcd_ssd_pkg holds: command field offsets/widths, MAX_LEN=4096, BEAT_BYTES=8, and the state enum.
REQ-038 One sub-module, mcd_ssd_beat_cnt (load/decrement/zero-flag counter), is shared by both data phases.

Verification
REQ-039 Read addr=0x200, len=64 -> cmd_dramRdData_data={13'd64,32'h200}; 8 beats forwarded; last on beat 8; one done.
REQ-040 Write len=13 with the node holding dramWrData_ready low 5 cycles -> 2 beats forwarded in order; done only after ncq_idle=1.
REQ-041 req_len=0, then req_len=4097 -> err pulses twice; no command valid is ever asserted.
REQ-042 link_initialized drops during RD_DATA after 3 of 8 beats -> err pulses; state IDLE; req_ready=0 until the link returns.
REQ-043 reset156 pulsed mid-WR_DATA -> all outputs 0 next cycle; a following read completes normally.
REQ-044 With MCD_SSD_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, read with no dramRdData_valid -> err at cycle 16 of RD_DATA; state IDLE.
